phy_rx_lane: RTL

Serial receive lane for the PHY link: the receiving end of one `phy_tx` serial output (`data_outS0`/`data_outS1`). Runs entirely on `clk_8f`, samples one bit per cycle MSB-first, finds byte alignment by hunting for the COM symbol, and declares the lane active after a run of aligned COMs. Once active it deframes the stream into bytes: COM bytes become idle cycles, all other bytes become valid data. The PHY receive side instantiates one lane per serial wire.

---
 rtl/phy_rx_lane_if.sv | 49 ++++
 rtl/phy_rx_lane.sv | 136 +++++++++++++
 2 files changed

// File: rtl/phy_rx_lane_if.sv
// ---------------------------------------------------------------------------
// phy_rx_lane_if
//
// Purpose : bundles the serial input and the deframed byte outputs of one
//           PHY receive lane.
//
// Signals :
//   data_inS    serial bit stream into the lane, MSB of each byte first
//   data_out    last data byte received
//   valid_out   data_out holds a data byte, not an idle COM
//   byte_strobe one-cycle pulse per completed byte while the lane is active
//   active      lane has achieved byte alignment
//   state_dbg   current FSM state (0 SEARCH, 1 ALIGN, 2 ACTIVE)
//
// Handshake : the output side is a valid-only stream with no backpressure.
//             A byte is transferred on every cycle where byte_strobe is 1;
//             valid_out qualifies whether that byte is data (1) or idle (0).
//             data_out/valid_out hold steady between strobes.
//
// Modports :
//   slave  - the lane itself (consumes data_inS, drives everything else)
//   master - the serial source / downstream observer
// ---------------------------------------------------------------------------
interface phy_rx_lane_if;
   logic       data_inS;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;
   logic [1:0] state_dbg;

   modport slave (
      input  data_inS,
      output data_out,
      output valid_out,
      output byte_strobe,
      output active,
      output state_dbg
   );

   modport master (
      output data_inS,
      input  data_out,
      input  valid_out,
      input  byte_strobe,
      input  active,
      input  state_dbg
   );
endinterface

// File: rtl/phy_rx_lane.sv
// ---------------------------------------------------------------------------
// phy_rx_lane
//
// Purpose : receive end of one serial PHY wire. Samples one bit per clk_8f
//           edge MSB-first, hunts bit-by-bit for the COM symbol, confirms
//           alignment with SYNC_COUNT consecutive aligned COMs, then deframes
//           the stream: COM bytes become idle strobes, every other byte is
//           presented as valid data.
//
// Parameters :
//   COM        idle/alignment symbol (default 8'hBC)
//   SYNC_COUNT aligned COMs needed to go active, legal range 2..15
//
// Ports :
//   clk_8f  bit clock, one serial bit per rising edge
//   reset   synchronous active-low reset
//   lane    phy_rx_lane_if.slave (serial in, byte outputs, state_dbg)
//
// All outputs are registered. A byte whose last bit is sampled at edge N
// appears on data_out/valid_out/byte_strobe during cycle N+1.
// ---------------------------------------------------------------------------
module phy_rx_lane #(
   parameter logic [7:0] COM        = 8'hBC,
   parameter int         SYNC_COUNT = 4
) (
   input  logic            clk_8f,
   input  logic            reset,
   phy_rx_lane_if.slave    lane
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   // com_cnt value at which the next aligned COM completes the sync run;
   // equivalent to testing com_cnt + 1 == SYNC_COUNT without widening.
   localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

   state_t     state;
   logic [7:0] sr;
   logic [2:0] bit_cnt;
   logic [3:0] com_cnt;

   logic [7:0] data_q;
   logic       valid_q;
   logic       strobe_q;
   logic       active_q;

   // Byte window including the bit being sampled this cycle; every
   // decision is made on this so a byte is acted on at its last bit.
   logic [7:0] nxt;
   logic       nxt_is_com;
   logic       byte_done;

   assign nxt        = {sr[6:0], lane.data_inS};
   assign nxt_is_com = (nxt == COM);
   assign byte_done  = (bit_cnt == 3'd7);

   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         state    <= ST_SEARCH;
         sr       <= 8'h00;
         bit_cnt  <= 3'd0;
         com_cnt  <= 4'd0;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
         active_q <= 1'b0;
      end else begin
         sr       <= nxt;
         strobe_q <= 1'b0;

         case (state)
            ST_SEARCH: begin
               // Bit-by-bit hunt: the first COM seen fixes byte alignment
               // and counts as the first COM of the sync run.
               if (nxt_is_com) begin
                  state   <= ST_ALIGN;
                  bit_cnt <= 3'd0;
                  com_cnt <= 4'd1;
               end
            end

            ST_ALIGN: begin
               // Wraps 7 -> 0 naturally, so ACTIVE starts byte-aligned.
               bit_cnt <= bit_cnt + 3'd1;
               if (byte_done) begin
                  if (nxt_is_com) begin
                     if (com_cnt == SYNC_LAST) begin
                        // The sync-completing COM is consumed silently.
                        state    <= ST_ACTIVE;
                        active_q <= 1'b1;
                     end else begin
                        com_cnt <= com_cnt + 4'd1;
                     end
                  end else begin
                     // Run broken: drop this byte and restart the hunt on
                     // the very next bit.
                     state   <= ST_SEARCH;
                     com_cnt <= 4'd0;
                  end
               end
            end

            ST_ACTIVE: begin
               // No loss-of-sync detection; only reset leaves this state.
               bit_cnt <= bit_cnt + 3'd1;
               if (byte_done) begin
                  strobe_q <= 1'b1;
                  if (nxt_is_com) begin
                     // Idle byte: keep the last data byte visible.
                     valid_q <= 1'b0;
                  end else begin
                     data_q  <= nxt;
                     valid_q <= 1'b1;
                  end
               end
            end

            default: begin
               state   <= ST_SEARCH;
               com_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign lane.data_out    = data_q;
   assign lane.valid_out   = valid_q;
   assign lane.byte_strobe = strobe_q;
   assign lane.active      = active_q;
   assign lane.state_dbg   = state;

endmodule
